// File: rtl/fp_addsub_pkg.sv
// fp_addsub_pkg: operand classes, special-value builders and exception-flag indices for the FP add/sub special-case pipe
package fp_addsub_pkg;
  typedef enum logic [1:0] {ZERO = 2'd0, INF = 2'd1, NAN = 2'd2, NORM = 2'd3} fp_class_t;
  localparam int FLAG_NAN_IN = 0;
  localparam int FLAG_INFINITE = 1;
  localparam int FLAG_INVALID = 2;
  function automatic logic [127:0] canon_nan(input int exp_w, input int man_w);
    return (128'd1 << (exp_w + man_w)) - 128'd1;
  endfunction
  function automatic logic [127:0] signed_inf(input logic s, input int exp_w, input int man_w);
    return ({127'd0, s} << (exp_w + man_w)) | (((128'd1 << exp_w) - 128'd1) << man_w);
  endfunction
endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational ZERO/INF/NAN/NORM classifier; x = {exponent, mantissa} (sign excluded), cls = class
module fp_classify
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int FTZ = 1
) (
  input  logic [EXP_W+MAN_W-1:0] x,
  output fp_class_t              cls
);
  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;
  assign e = x[MAN_W+:EXP_W];
  assign m = x[MAN_W-1:0];
  assign cls = &e ? (|m ? NAN : INF) : (e == '0 && (FTZ != 0 || m == '0)) ? ZERO : NORM;
endmodule

// File: rtl/fp_addsub_special_pipe.sv
// fp_addsub_special_pipe: pipelined add/sub special-case resolver merged with the datapath core result
// Ports: clk/rst (sync, active-high); in_valid/in_ready/op_sub/a/b operand side; pipe_en shared core advance;
// core_result from the core for the tail entry; out_valid/out_ready/result output side.
// Define FP_ADDSUB_EXC_FLAGS_EN to add exc_flags[2:0] = {invalid, infinite, nan_in}.
module fp_addsub_special_pipe
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CORE_LAT = 3,
  parameter int FTZ = 1,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         pipe_en,
  input  logic [W-1:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result
`ifdef FP_ADDSUB_EXC_FLAGS_EN
  ,
  output logic [2:0]   exc_flags
`endif
);
  localparam logic [W-1:0] NAN_V = W'(canon_nan(EXP_W, MAN_W));
  localparam logic [W-1:0] INF_P = W'(signed_inf(1'b0, EXP_W, MAN_W));
  localparam logic [W-1:0] INF_N = W'(signed_inf(1'b1, EXP_W, MAN_W));
  logic acc, sa, sb, hit_in;
  logic [W-1:0] b_eff, val_in;
  fp_class_t ca, cb;
  logic [CORE_LAT-1:0] v_q, hit_q;
  logic [W-1:0] val_q [CORE_LAT];
  // reset forces the advance so the consumer never sees a stalled pipe while it is being cleared
  assign pipe_en = rst | ~(out_valid & ~out_ready);
  assign in_ready = pipe_en;
  assign acc = in_valid & in_ready;
  assign b_eff = {b[W-1] ^ op_sub, b[W-2:0]};
  assign sa = a[W-1];
  assign sb = b_eff[W-1];
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FTZ(FTZ)) u_cls_a (.x(a[W-2:0]), .cls(ca));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FTZ(FTZ)) u_cls_b (.x(b_eff[W-2:0]), .cls(cb));
  always_comb begin
    hit_in = 1'b1;
    val_in = '0;
    if (ca == NAN || cb == NAN) val_in = NAN_V;
    else if (ca == INF && cb == INF) val_in = (sa != sb) ? NAN_V : (sa ? INF_N : INF_P);
    else if (ca == INF) val_in = sa ? INF_N : INF_P;
    else if (cb == INF) val_in = sb ? INF_N : INF_P;
    else if (ca == ZERO && cb == ZERO) val_in = {sa & sb, {(W-1){1'b0}}};
    else if (ca == ZERO) val_in = b_eff;
    else if (cb == ZERO) val_in = a;
    else hit_in = 1'b0;
  end
`ifdef FP_ADDSUB_EXC_FLAGS_EN
  logic [2:0] flg_in;
  logic [2:0] flg_q [CORE_LAT];
  assign flg_in[FLAG_NAN_IN] = ca == NAN || cb == NAN;
  assign flg_in[FLAG_INVALID] = !flg_in[FLAG_NAN_IN] && ca == INF && cb == INF && sa != sb;
  assign flg_in[FLAG_INFINITE] = !flg_in[FLAG_NAN_IN] && !flg_in[FLAG_INVALID] && (ca == INF || cb == INF);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      out_valid <= 1'b0;
      result <= '0;
`ifdef FP_ADDSUB_EXC_FLAGS_EN
      exc_flags <= '0;
`endif
    end else if (pipe_en) begin
      v_q[0] <= acc;
      hit_q[0] <= hit_in;
      val_q[0] <= val_in;
      for (int i = 1; i < CORE_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        hit_q[i] <= hit_q[i-1];
        val_q[i] <= val_q[i-1];
      end
      out_valid <= v_q[CORE_LAT-1];
      result <= hit_q[CORE_LAT-1] ? val_q[CORE_LAT-1] : core_result;
`ifdef FP_ADDSUB_EXC_FLAGS_EN
      flg_q[0] <= flg_in;
      for (int i = 1; i < CORE_LAT; i++) flg_q[i] <= flg_q[i-1];
      exc_flags <= flg_q[CORE_LAT-1];
`endif
    end
  end
endmodule
